// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-read-port MIPS register file.
// MIPS register names, default stack-pointer reset value, legal-write check.
package reg_file_pkg;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_AT   = 1;
    localparam int unsigned REG_V0   = 2;
    localparam int unsigned REG_V1   = 3;
    localparam int unsigned REG_A0   = 4;
    localparam int unsigned REG_A1   = 5;
    localparam int unsigned REG_A2   = 6;
    localparam int unsigned REG_A3   = 7;
    localparam int unsigned REG_T0   = 8;
    localparam int unsigned REG_T1   = 9;
    localparam int unsigned REG_T2   = 10;
    localparam int unsigned REG_T3   = 11;
    localparam int unsigned REG_T4   = 12;
    localparam int unsigned REG_T5   = 13;
    localparam int unsigned REG_T6   = 14;
    localparam int unsigned REG_T7   = 15;
    localparam int unsigned REG_S0   = 16;
    localparam int unsigned REG_S1   = 17;
    localparam int unsigned REG_S2   = 18;
    localparam int unsigned REG_S3   = 19;
    localparam int unsigned REG_S4   = 20;
    localparam int unsigned REG_S5   = 21;
    localparam int unsigned REG_S6   = 22;
    localparam int unsigned REG_S7   = 23;
    localparam int unsigned REG_T8   = 24;
    localparam int unsigned REG_T9   = 25;
    localparam int unsigned REG_K0   = 26;
    localparam int unsigned REG_K1   = 27;
    localparam int unsigned REG_GP   = 28;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_FP   = 30;
    localparam int unsigned REG_RA   = 31;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;

    // A write commits only to a nonzero address that exists in the file.
    function automatic logic legal_write(input logic [31:0] addr, input int unsigned depth);
        return (addr != 32'd0) && (addr < depth);
    endfunction

endpackage

// File: rtl/mux_n_1.sv
// N-to-1 data multiplexer over a packed bus; a select beyond NUM_IN yields 0.
module mux_n_1 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_IN = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic [NUM_IN*DATA_W-1:0] i_data,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [DATA_W-1:0]        o_data
);

    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(i_sel) == i) begin
                o_data = i_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reg_file_np.sv
// Parametrised register file: one synchronous write port, NUM_RD combinational reads.
// Optional write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_np
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned SP_IDX  = 29,
    parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    output logic [15:0]              wr_cnt_o
);

    // Register 0 has no storage; its read slot is tied to zero.
    logic [DATA_W-1:0]       r_regs [1:DEPTH-1];
    logic [15:0]             r_wr_cnt;
    logic                    w_we_legal;
    logic [DEPTH*DATA_W-1:0] w_rd_bus;

    assign w_we_legal = we_i && legal_write(32'(waddr_i), DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
            r_wr_cnt <= '0;
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (w_we_legal && (waddr_i == ADDR_W'(i))) begin
                    r_regs[i] <= wdata_i;
                end
            end
            if (w_we_legal && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_rd_bus = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            w_rd_bus[i*DATA_W +: DATA_W] = r_regs[i];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [DATA_W-1:0] w_mux;

        mux_n_1 #(
            .DATA_W (DATA_W),
            .NUM_IN (DEPTH),
            .SEL_W  (ADDR_W)
        ) u_mux (
            .i_data (w_rd_bus),
            .i_sel  (raddr_i[k*ADDR_W +: ADDR_W]),
            .o_data (w_mux)
        );

`ifdef REG_FILE_BYPASS_EN
        // A legal write already excludes address 0, so forwarding never breaks the zero read.
        assign rdata_o[k*DATA_W +: DATA_W] =
            (w_we_legal && (raddr_i[k*ADDR_W +: ADDR_W] == waddr_i)) ? wdata_i : w_mux;
`else
        assign rdata_o[k*DATA_W +: DATA_W] = w_mux;
`endif
    end

    assign wr_cnt_o = r_wr_cnt;

endmodule

// File: tb/tb_reg_file_np.sv
// Self-checking bench for reg_file_np: DEPTH=32 and DEPTH=16 instances, directed vectors.
`timescale 1ns/100ps
module tb_reg_file_np;

    logic        clk;
    logic        rst_n;

    logic        we32;
    logic [4:0]  waddr32;
    logic [31:0] wdata32;
    logic [9:0]  raddr32;
    logic [63:0] rdata32;
    logic [15:0] cnt32;

    logic        we16;
    logic [4:0]  waddr16;
    logic [31:0] wdata16;
    logic [9:0]  raddr16;
    logic [63:0] rdata16;
    logic [15:0] cnt16;

    int checks;
    int failures;

    reg_file_np #(.DEPTH(32)) u_dut32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (we32),
        .waddr_i  (waddr32),
        .wdata_i  (wdata32),
        .raddr_i  (raddr32),
        .rdata_o  (rdata32),
        .wr_cnt_o (cnt32)
    );

    reg_file_np #(.DEPTH(16)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (we16),
        .waddr_i  (waddr16),
        .wdata_i  (wdata16),
        .raddr_i  (raddr16),
        .rdata_o  (rdata16),
        .wr_cnt_o (cnt16)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] same_cycle_exp;
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd1};
        vecs[1] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd8,  32'h0000_0000, 32'hDEAD_BEEF, 16'd1};
        vecs[2] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd29, 32'hCAFE_F00D, 32'h7FFF_EFFC, 16'd2};
        vecs[3] = '{1'b1, 5'd29, 32'h1000_0000, 5'd29, 5'd0,  32'h1000_0000, 32'h0000_0000, 16'd3};
        vecs[4] = '{1'b0, 5'd8,  32'hFFFF_FFFF, 5'd8,  5'd31, 32'hDEAD_BEEF, 32'hCAFE_F00D, 16'd3};
        vecs[5] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd2,  32'h0000_0001, 32'h0000_0000, 16'd4};
        vecs[6] = '{1'b1, 5'd8,  32'h0000_0000, 5'd8,  5'd1,  32'h0000_0000, 32'h0000_0001, 16'd5};

        rst_n = 1'b1;
        we32 = 1'b0; waddr32 = '0; wdata32 = '0; raddr32 = {5'd29, 5'd0};
        we16 = 1'b0; waddr16 = '0; wdata16 = '0; raddr16 = {5'd29, 5'd15};

        // Asynchronous reset asserted mid-cycle, well before the first rising edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst_rd0_addr0",  rdata32[31:0],  32'h0);
        check("rst_rd1_sp",     rdata32[63:32], 32'h7FFF_EFFC);
        check("rst_cnt",        32'(cnt32),     32'h0);
        check("rst16_rd1_29",   rdata16[63:32], 32'h0);
        raddr32[4:0] = 5'd31;
        #1;
        check("rst_rd0_addr31", rdata32[31:0],  32'h0);
        #9 rst_n = 1'b1;

        foreach (vecs[v]) begin
            @(negedge clk);
            we32    = vecs[v].we;
            waddr32 = vecs[v].waddr;
            wdata32 = vecs[v].wdata;
            raddr32 = {vecs[v].ra1, vecs[v].ra0};
            @(posedge clk);
            #1 we32 = 1'b0;
            #1;
            check($sformatf("vec%0d_rd0", v), rdata32[31:0],  vecs[v].exp0);
            check($sformatf("vec%0d_rd1", v), rdata32[63:32], vecs[v].exp1);
            check($sformatf("vec%0d_cnt", v), 32'(cnt32),     32'(vecs[v].exp_cnt));
        end

        // DEPTH=16: a legal write, then an out-of-range write that must be dropped.
        @(negedge clk);
        we16 = 1'b1; waddr16 = 5'd15; wdata16 = 32'h0F0F_0F0F;
        @(negedge clk);
        waddr16 = 5'd20; wdata16 = 32'h1234_5678;
        @(negedge clk);
        waddr16 = 5'd16; wdata16 = 32'h5555_AAAA;
        @(negedge clk);
        we16 = 1'b0;
        raddr16 = {5'd15, 5'd20};
        #1;
        check("d16_rd_addr20", rdata16[31:0],  32'h0);
        check("d16_rd_addr15", rdata16[63:32], 32'h0F0F_0F0F);
        check("d16_cnt",       32'(cnt16),     32'h1);
        raddr16 = {5'd4, 5'd16};
        #1;
        check("d16_rd_addr16", rdata16[31:0],  32'h0);
        check("d16_rd_addr4",  rdata16[63:32], 32'h0);

        // Same-cycle write and read of address 5.
        @(negedge clk);
        we32 = 1'b1; waddr32 = 5'd5; wdata32 = 32'hA5A5_A5A5;
        raddr32 = {5'd0, 5'd5};
`ifdef REG_FILE_BYPASS_EN
        same_cycle_exp = 32'hA5A5_A5A5;
`else
        same_cycle_exp = 32'h0;
`endif
        #1;
        check("wr_rd_same_pre",  rdata32[31:0],  same_cycle_exp);
        check("wr_rd_same_zero", rdata32[63:32], 32'h0);
        @(posedge clk);
        #1;
        check("wr_rd_same_post", rdata32[31:0],  32'hA5A5_A5A5);
        we32 = 1'b0;
        #1;
        check("wr_rd_same_cnt",  32'(cnt32),     32'd6);

        // Continuous writes to address 3 drive the counter into saturation.
        @(negedge clk);
        we32 = 1'b1; waddr32 = 5'd3; wdata32 = 32'h3333_3333;
        raddr32 = {5'd29, 5'd3};
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("sat_cnt",  32'(cnt32),     32'h0000_FFFF);
        check("sat_reg3", rdata32[31:0],  32'h3333_3333);

        // Reset lands while the write is still active.
        #3 rst_n = 1'b0;
        #1;
        check("midrst_reg3", rdata32[31:0],  32'h0);
        check("midrst_sp",   rdata32[63:32], 32'h7FFF_EFFC);
        check("midrst_cnt",  32'(cnt32),     32'h0);
        @(posedge clk);
        #1;
        check("midrst_hold_reg3", rdata32[31:0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wdata32 = 32'h0000_0077;
        @(posedge clk);
        #1 we32 = 1'b0;
        #1;
        check("resume_reg3", rdata32[31:0], 32'h0000_0077);
        check("resume_cnt",  32'(cnt32),    32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
